// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUOp/funct/ALU-control encodings, writeback selects and sequencer states
package alu_ctrl_pkg;
  localparam logic [2:0] OP_R     = 3'b010;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_BNE   = 3'b001;
  localparam logic [2:0] OP_SLTIU = 3'b111;
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_ORI   = 3'b110;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADDU  = 4'b0010;
  localparam logic [3:0] C_SRAV  = 4'b0011;
  localparam logic [3:0] C_BEQ   = 4'b0100;
  localparam logic [3:0] C_SLTIU = 4'b0101;
  localparam logic [3:0] C_SUBU  = 4'b0110;
  localparam logic [3:0] C_SLT   = 4'b0111;
  localparam logic [3:0] C_ADDI  = 4'b1000;
  localparam logic [3:0] C_ORI   = 4'b1001;
  localparam logic [3:0] C_BNE   = 4'b1010;
  localparam logic [3:0] C_SRA   = 4'b1101;
  localparam logic [3:0] C_LUI   = 4'b1110;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  function automatic logic [3:0] alu_ctrl(input logic [2:0] op, input logic [5:0] f);
    case (op)
      OP_R:
        case (f)
          F_ADDU:  return C_ADDU;
          F_SUBU:  return C_SUBU;
          F_OR:    return C_OR;
          F_SLT:   return C_SLT;
          F_SRA:   return C_SRA;
          F_SRAV:  return C_SRAV;
          default: return C_AND;
        endcase
      OP_ADDI:  return C_ADDI;
      OP_BEQ:   return C_BEQ;
      OP_BNE:   return C_BNE;
      OP_SLTIU: return C_SLTIU;
      OP_LUI:   return C_LUI;
      OP_ORI:   return C_ORI;
      default:  return C_AND;
    endcase
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider datapath
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic         is_div,
  input  logic         step,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  output logic         last,
  output logic [W-1:0] nxt_hi,
  output logic [W-1:0] nxt_lo
);
  localparam int CW = $clog2(W);
  logic [W-1:0] acc, sh, opnd;
  logic [CW-1:0] cnt;
  logic div_mode, ge;
  logic [W:0] sum, rem, dif;
  // remainder stays below the divisor, so the borrow bit alone tells whether to subtract
  always_comb begin
    sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    rem = {acc, sh[W-1]};
    dif = rem - {1'b0, opnd};
    ge = !dif[W];
    nxt_hi = div_mode ? (ge ? dif[W-1:0] : rem[W-1:0]) : sum[W:1];
    nxt_lo = div_mode ? {sh[W-2:0], ge} : {sum[0], sh[W-1:1]};
  end
  assign last = cnt == CW'(W - 1);
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc <= '0;
      sh <= '0;
      opnd <= '0;
      cnt <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      acc <= '0;
      sh <= is_div ? src1 : src2;
      opnd <= is_div ? src2 : src1;
      cnt <= '0;
      div_mode <= is_div;
    end else if (step) begin
      acc <= nxt_hi;
      sh <= nxt_lo;
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decode plus iterative MULTU/DIVU sequencer owning HI/LO
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 3,
  parameter int CTRL_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [5:0]         funct_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic [1:0]         hilo_sel_o,
  output logic               stall_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);
  state_t state;
  logic is_r, is_mul, is_div, div0, last;
  logic [DATA_W-1:0] nxt_hi, nxt_lo;
  assign is_r = 3'(ALUOp_i) == OP_R;
  assign is_mul = valid_i & is_r & (funct_i == F_MULTU);
  assign is_div = valid_i & is_r & (funct_i == F_DIVU);
  assign div0 = src2_i == '0;
  assign ALUCtrl_o = CTRL_W'(alu_ctrl(3'(ALUOp_i), funct_i));
  assign hilo_sel_o = !is_r ? SEL_ALU : funct_i == F_MFHI ? SEL_HI : funct_i == F_MFLO ? SEL_LO : SEL_ALU;
  assign stall_o = rst_i & ((state == S_IDLE & (is_mul | is_div)) | state == S_MUL | state == S_DIV);
  muldiv_iter #(.W(DATA_W)) u_md (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (state == S_IDLE & (is_mul | (is_div & !div0))),
    .is_div (is_div),
    .step   (state == S_MUL | state == S_DIV),
    .src1   (src1_i),
    .src2   (src2_i),
    .last   (last),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      hi_o <= '0;
      lo_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE:
          if (is_mul) state <= S_MUL;
          else if (is_div & !div0) state <= S_DIV;
          else if (is_div) begin
            hi_o <= src1_i;
            lo_o <= '1;
            done_o <= 1'b1;
            state <= S_DONE;
          end
        S_MUL, S_DIV:
          if (last) begin
            hi_o <= nxt_hi;
            lo_o <= nxt_lo;
            done_o <= 1'b1;
            state <= S_DONE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: decode table plus directed/random MULTU/DIVU checks on 32- and 8-bit instances
module tb_alu_ctrl_seq;
  logic clk = 1'b0, rst = 1'b0, v32 = 1'b0, v8 = 1'b0, use8 = 1'b0;
  logic [2:0] op = '0;
  logic [5:0] funct = '0;
  logic [31:0] s1 = '0, s2 = '0;
  logic [3:0] ctrl32, ctrl8;
  logic [1:0] sel32, sel8;
  logic stall32, done32, stall8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0] hi8, lo8;
  logic stall_s, done_s;
  logic [31:0] hi_s, lo_s;
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.DATA_W(32), .ALUOP_W(3), .CTRL_W(4)) u32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .ALUOp_i(op), .funct_i(funct),
    .src1_i(s1), .src2_i(s2), .ALUCtrl_o(ctrl32), .hilo_sel_o(sel32),
    .stall_o(stall32), .done_o(done32), .hi_o(hi32), .lo_o(lo32));

  alu_ctrl_seq #(.DATA_W(8), .ALUOP_W(3), .CTRL_W(4)) u8 (
    .clk_i(clk), .rst_i(rst), .valid_i(v8), .ALUOp_i(op), .funct_i(funct),
    .src1_i(s1[7:0]), .src2_i(s2[7:0]), .ALUCtrl_o(ctrl8), .hilo_sel_o(sel8),
    .stall_o(stall8), .done_o(done8), .hi_o(hi8), .lo_o(lo8));

  assign stall_s = use8 ? stall8 : stall32;
  assign done_s = use8 ? done8 : done32;
  assign hi_s = use8 ? {24'b0, hi8} : hi32;
  assign lo_s = use8 ? {24'b0, lo8} : lo32;

  typedef struct {
    logic [2:0] op;
    logic [5:0] f;
    logic       v;
    logic [3:0] ctrl;
    logic [1:0] sel;
    logic       stall;
  } dvec_t;
  dvec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one MULTU/DIVU; returns while the done cycle is being observed.
  task automatic muldiv(input logic div, input logic [31:0] a_in, input logic [31:0] b_in, input logic from_done);
    int k, w, lat, cyc, bad;
    logic [31:0] msk, a, b;
    logic [63:0] p;
    k = use8 ? 1 : 0;
    w = use8 ? 8 : 32;
    msk = use8 ? 32'h0000_00ff : 32'hffff_ffff;
    a = a_in & msk;
    b = b_in & msk;
    if (use8) v8 = 1'b1; else v32 = 1'b1;
    op = 3'b010;
    funct = div ? 6'b011011 : 6'b011001;
    s1 = a;
    s2 = b;
    #1;
    if (from_done) begin
      chk("no_start_in_done", 64'(stall_s), 64'(0));
      tick;
    end
    chk("stall_at_accept", 64'(stall_s), 64'(1));
    lat = (div && b == 0) ? 1 : w + 1;
    tick;
    v8 = 1'b0;
    v32 = 1'b0;
    s1 = $urandom;
    s2 = $urandom;
    #1;
    cyc = 1;
    bad = 0;
    while (done_s !== 1'b1 && cyc < 80) begin
      if (stall_s !== 1'b1 || hi_s !== mhi[k] || lo_s !== mlo[k]) bad++;
      tick;
      cyc++;
    end
    if (!div) begin
      p = {32'b0, a} * {32'b0, b};
      mhi[k] = use8 ? {24'b0, p[15:8]} : p[63:32];
      mlo[k] = use8 ? {24'b0, p[7:0]} : p[31:0];
    end else if (b == 0) begin
      mhi[k] = a;
      mlo[k] = msk;
    end else begin
      mlo[k] = a / b;
      mhi[k] = a % b;
    end
    chk(div ? "div_busy_cycles" : "mul_busy_cycles", 64'(bad), 64'(0));
    chk(div ? "div_latency" : "mul_latency", 64'(cyc), 64'(lat));
    chk("stall_low_at_done", 64'(stall_s), 64'(0));
    chk(div ? "div_hi" : "mul_hi", 64'(hi_s), 64'(mhi[k]));
    chk(div ? "div_lo" : "mul_lo", 64'(lo_s), 64'(mlo[k]));
  endtask

  task automatic after_done;
    tick;
    chk("done_single_pulse", 64'(done_s), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic div;
    logic [31:0] a, b;
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    // reset with a MULTU presented: must be ignored
    v32 = 1'b1; v8 = 1'b1; op = 3'b010; funct = 6'b011001; s1 = 5; s2 = 3;
    tick;
    tick;
    chk("rst_stall32", 64'(stall32), 64'(0));
    chk("rst_stall8", 64'(stall8), 64'(0));
    chk("rst_done32", 64'(done32), 64'(0));
    chk("rst_hi32", 64'(hi32), 64'(0));
    chk("rst_lo32", 64'(lo32), 64'(0));
    v32 = 1'b0; v8 = 1'b0; rst = 1'b1;
    tick;
    chk("post_rst_stall", 64'(stall32), 64'(0));
    chk("post_rst_done", 64'(done32), 64'(0));

    tbl.push_back('{3'b010, 6'b100001, 1'b1, 4'b0010, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b100011, 1'b1, 4'b0110, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b100101, 1'b1, 4'b0001, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b100100, 1'b1, 4'b0000, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b101010, 1'b1, 4'b0111, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b000011, 1'b1, 4'b1101, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b000111, 1'b1, 4'b0011, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b010000, 1'b1, 4'b0000, 2'b01, 1'b0});
    tbl.push_back('{3'b010, 6'b010010, 1'b1, 4'b0000, 2'b10, 1'b0});
    tbl.push_back('{3'b010, 6'b111111, 1'b1, 4'b0000, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b011001, 1'b0, 4'b0000, 2'b00, 1'b0});
    tbl.push_back('{3'b010, 6'b011011, 1'b0, 4'b0000, 2'b00, 1'b0});
    tbl.push_back('{3'b100, 6'b100001, 1'b1, 4'b1000, 2'b00, 1'b0});
    tbl.push_back('{3'b011, 6'b100001, 1'b1, 4'b0100, 2'b00, 1'b0});
    tbl.push_back('{3'b001, 6'b100001, 1'b1, 4'b1010, 2'b00, 1'b0});
    tbl.push_back('{3'b111, 6'b100001, 1'b1, 4'b0101, 2'b00, 1'b0});
    tbl.push_back('{3'b101, 6'b100001, 1'b1, 4'b1110, 2'b00, 1'b0});
    tbl.push_back('{3'b110, 6'b100001, 1'b1, 4'b1001, 2'b00, 1'b0});
    tbl.push_back('{3'b000, 6'b100001, 1'b1, 4'b0000, 2'b00, 1'b0});
    tbl.push_back('{3'b100, 6'b011001, 1'b1, 4'b1000, 2'b00, 1'b0});
    tbl.push_back('{3'b110, 6'b010010, 1'b1, 4'b1001, 2'b00, 1'b0});
    foreach (tbl[i]) begin
      op = tbl[i].op; funct = tbl[i].f; v32 = tbl[i].v;
      #1;
      chk($sformatf("dec%0d_ctrl", i), 64'(ctrl32), 64'(tbl[i].ctrl));
      chk($sformatf("dec%0d_sel", i), 64'(sel32), 64'(tbl[i].sel));
      chk($sformatf("dec%0d_stall", i), 64'(stall32), 64'(tbl[i].stall));
    end
    v32 = 1'b0;
    tick;

    use8 = 1'b0;
    muldiv(1'b0, 32'd7, 32'd6, 1'b0); after_done;
    muldiv(1'b0, 32'hffff_ffff, 32'hffff_ffff, 1'b0); after_done;
    muldiv(1'b1, 32'd100, 32'd7, 1'b0);
    muldiv(1'b1, 32'd100, 32'd7, 1'b1); after_done;
    muldiv(1'b1, 32'h1234, 32'd0, 1'b0); after_done;
    op = 3'b010; funct = 6'b010000; v32 = 1'b1;
    #1;
    chk("mfhi_sel", 64'(sel32), 64'(2'b01));
    chk("mfhi_no_stall", 64'(stall32), 64'(0));
    chk("mfhi_reads_hi", 64'(hi32), 64'(32'h1234));
    v32 = 1'b0;
    tick;

    for (int i = 0; i < 24; i++) begin
      use8 = 1'($urandom_range(0, 1));
      div = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      muldiv(div, a, b, 1'b0);
      after_done;
    end

    // reset in the middle of a multiply
    use8 = 1'b0;
    muldiv(1'b0, 32'd7, 32'd6, 1'b0); after_done;
    v32 = 1'b1; op = 3'b010; funct = 6'b011001; s1 = 32'd123; s2 = 32'd456;
    tick;
    v32 = 1'b0;
    repeat (9) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0;
    chk("midrst_stall", 64'(stall32), 64'(0));
    chk("midrst_hi", 64'(hi32), 64'(0));
    chk("midrst_lo", 64'(lo32), 64'(0));
    chk("midrst_done", 64'(done32), 64'(0));
    dones = 0;
    repeat (40) begin
      tick;
      if (done32 === 1'b1 || stall32 !== 1'b0) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'(0));

    use8 = 1'b1;
    muldiv(1'b0, 32'd13, 32'd11, 1'b0);
    chk("w8_mul_lo_8f", 64'(lo8), 64'(8'h8f));
    after_done;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised ALU controller with an iterative multiply/divide sequencer for the multi-cycle CPU generation. It decodes ALUOp/funct to the ALU control code for single-cycle operations exactly as before. It also runs unsigned MULTU/DIVU over DATA_W cycles into HI/LO registers, stalling the pipeline while busy. It sits beside the main ALU, fed by the decoder and register-file read ports.

## Interface
- DATA_W, 32, operand/HI/LO width (≥4)
- ALUOP_W, 3, ALUOp width
- CTRL_W, 4, ALU control code width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-low reset
- valid_i  in  1  instruction in decode stage is valid
- ALUOp_i  in  ALUOP_W  main-decoder ALU op class
- funct_i  in  6  R-type funct field
- src1_i  in  DATA_W  rs operand (multiplicand / dividend)
- src2_i  in  DATA_W  rt operand (multiplier / divisor)
- ALUCtrl_o  out  CTRL_W  ALU control code (combinational)
- hilo_sel_o  out  2  writeback select: 00 ALU, 01 HI (MFHI), 10 LO (MFLO)
- stall_o  out  1  hold PC/pipeline
- done_o  out  1  one-cycle pulse, mul/div result committed
- hi_o, lo_o  out  DATA_W each  HI/LO registers

## Operation
- ALUOp classes: 010 R-type, 100 addi, 011 beq, 001 bne, 111 sltiu, 101 lui, 110 ori; any other → ALUCtrl_o=0000.
- R-type funct → ALUCtrl_o: 100001 addu→0010, 100011 subu→0110, 100101 or→0001, 100100 and→0000, 101010 slt→0111, 000011 sra→1101, 000111 srav→0011; non-R classes: lui 1110, addi 1000, beq 0100, bne 1010, sltiu 0101, ori 1001.
- New R-type funct: 011001 MULTU, 011011 DIVU, 010000 MFHI (hilo_sel_o=01), 010010 MFLO (hilo_sel_o=10). ALUCtrl_o=0000 for these four.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE: valid_i & MULTU → latch operands, cnt=0, →MUL; valid_i & DIVU & src2_i≠0 → →DIV; valid_i & DIVU & src2_i=0 → HI=src1_i, LO=all-ones, →DONE.
  - MUL: shift-add, one multiplier bit per cycle, 2·DATA_W product; after cnt=DATA_W−1 write HI=product[2W−1:W], LO=product[W−1:0], →DONE.
  - DIV: restoring shift-subtract, one quotient bit per cycle; after cnt=DATA_W−1 write LO=quotient, HI=remainder, →DONE.
  - DONE: done_o=1, →IDLE unconditionally; a new mul/div is not started from DONE.
- cnt width $clog2(DATA_W); HI/LO change only on completion or reset.
- stall_o = (IDLE & valid_i & (MULTU|DIVU)) | MUL | DIV. Low in DONE, so the issuing instruction retires then.
- MFHI/MFLO issued while busy cannot happen (pipeline stalled); in IDLE/DONE they read the committed HI/LO.

## Timing
- Reset (rst_i=0 at an edge): state IDLE, cnt 0, hi_o=lo_o=0, done_o=0, stall_o=0 (valid_i ignored the reset cycle), internal operand/accumulator regs 0.
- ALUCtrl_o and hilo_sel_o: combinational, zero latency.
- MULTU/DIVU (nonzero divisor) accepted at edge 0 → stall_o high cycles 0..DATA_W, HI/LO valid and done_o high in cycle DATA_W+1, stall_o low that cycle; next mul/div start no earlier than cycle DATA_W+2.
- DIVU by zero: stall_o high cycle 0 only, done_o and HI/LO in cycle 1.
- Reset mid-operation: aborts, HI/LO cleared to 0, no done_o.
- Operands sampled only at acceptance; later src changes ignored.

## Structure
- Package alu_ctrl_pkg: ALUOp class constants, funct constants (incl. MULTU/DIVU/MFHI/MFLO), ALUCtrl codes, hilo_sel codes, FSM state typedef.
- Sub-module muldiv_iter: parametrised shift-add/shift-subtract datapath (accumulator, shift regs, cnt); alu_ctrl_seq holds decode, FSM, HI/LO.

## Test plan
- Decode sweep: R-type addu (010/100001) → 0010; srav → 0011; ori class 110 → 1001; undefined class 000 → 0000; MFLO → hilo_sel_o=10, no stall.
- MULTU 7×6 (DATA_W=32) → stall 33 cycles, done_o cycle 33, LO=42, HI=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 → LO=14, HI=2 after 33-cycle latency; back-to-back DIVU starts cycle 34.
- DIVU 0x1234/0 → done_o cycle 1, HI=0x1234, LO=0xFFFFFFFF.
- rst_i low at cycle 10 of MULTU → IDLE, HI=LO=0, stall_o=0, no done_o; repeat MULTU 13×11 with DATA_W=8 → LO=0x8F, HI=0x00, done cycle 9.
